// File: rtl/ofm_pool_pkg.sv
// rtl/ofm_pool_pkg.sv - shared FSM state type and default geometry for the 2x2 max-pool block
package ofm_pool_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    FINISH   = 2'd3
  } pool_state_e;

  localparam int DEF_DW    = 16;
  localparam int DEF_OFM_W = 16;
  localparam int DEF_OFM_H = 16;

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - one-row buffer of even-row pair maxima, single shared write/read address
module pool_line_buf
  import ofm_pool_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_OFM_W / 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Contents are deliberately not reset; an entry is always written before it is read in a frame.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ofm_pool.sv
// rtl/ofm_pool.sv - streaming 2x2/stride-2 signed max-pool over a raster conv output map
// Optional ReLU clamp of every input sample when POOL_RELU_EN is defined.
module ofm_pool
  import ofm_pool_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int OFM_W = DEF_OFM_W,
  parameter  int OFM_H = DEF_OFM_H,
  localparam int AW    = $clog2(OFM_W * OFM_H / 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic [AW-1:0]        out_addr,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (OFM_W > 1) ? $clog2(OFM_W) : 1;
  localparam int RW = (OFM_H > 1) ? $clog2(OFM_H) : 1;
  localparam int LW = (OFM_W / 2 > 1) ? $clog2(OFM_W / 2) : 1;

  pool_state_e          state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic signed [DW-1:0] hold_q, hold_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0]        out_addr_q, out_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic signed [DW-1:0] sample;
  logic signed [DW-1:0] pair_max;
  logic signed [DW-1:0] block_max;
  logic signed [DW-1:0] lb_rdata;
  logic                 lb_we;
  logic [LW-1:0]        lb_addr;
  logic                 col_last;
  logic                 row_last;
  logic [AW-1:0]        pool_addr;

`ifdef POOL_RELU_EN
  assign sample = in_data[DW-1] ? '0 : in_data;
`else
  assign sample = in_data;
`endif

  assign pair_max  = (sample > hold_q) ? sample : hold_q;
  assign block_max = (pair_max > lb_rdata) ? pair_max : lb_rdata;
  assign col_last  = (col_q == CW'(OFM_W - 1));
  assign row_last  = (row_q == RW'(OFM_H - 1));
  assign lb_addr   = LW'(col_q >> 1);
  assign lb_we     = in_valid && (state_q == EVEN_ROW) && col_q[0];
  assign pool_addr = AW'(AW'(row_q >> 1) * AW'(OFM_W / 2)) + AW'(col_q >> 1);

  pool_line_buf #(
    .DW   (DW),
    .DEPTH(OFM_W / 2)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .addr (lb_addr),
    .wdata(pair_max),
    .rdata(lb_rdata)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EVEN_ROW;
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end
      end
      EVEN_ROW, ODD_ROW: begin
        if (in_valid) begin
          if (!col_q[0]) begin
            hold_d = sample;
          end else if (state_q == ODD_ROW) begin
            out_valid_d = 1'b1;
            out_data_d  = block_max;
            out_addr_d  = pool_addr;
          end
          if (col_last) begin
            col_d = '0;
            if (state_q == EVEN_ROW) begin
              row_d   = row_q + 1'b1;
              state_d = ODD_ROW;
            end else if (row_last) begin
              row_d   = '0;
              state_d = FINISH;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = EVEN_ROW;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ofm_pool.sv
// tb/tb_ofm_pool.sv - self-checking bench for ofm_pool (4x4 and default 16x16 instances)
// Expected values follow POOL_RELU_EN when the bench is built with it defined.
module tb_ofm_pool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st4, v4, st16, v16;
  logic signed [15:0] d4, d16;
  logic ov4, ov16, busy4, busy16, done4, done16;
  logic signed [15:0] od4, od16;
  logic [1:0] oa4;
  logic [5:0] oa16;

  ofm_pool #(.DW(16), .OFM_W(4), .OFM_H(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .in_valid(v4), .in_data(d4),
    .out_valid(ov4), .out_data(od4), .out_addr(oa4), .busy(busy4), .done(done4)
  );

  ofm_pool u16 (
    .clk(clk), .rst(rst), .start(st16), .in_valid(v16), .in_data(d16),
    .out_valid(ov16), .out_data(od16), .out_addr(oa16), .busy(busy16), .done(done16)
  );

  typedef struct {
    int din;
    bit exp_v;
    int exp_d;
    int exp_a;
  } vec_t;

  int errors = 0;
  int checks = 0;
  bit big = 1'b0;
  int W = 4;
  int H = 4;

  // reference model state
  int phase;
  int k;
  int samp[$];
  logic e_valid, e_done, e_busy;
  int e_data, e_addr;
  int n_out;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int x);
`ifdef POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic cur_ov();
    return big ? ov16 : ov4;
  endfunction
  function automatic logic signed [31:0] cur_od();
    return big ? od16 : od4;
  endfunction
  function automatic logic signed [31:0] cur_oa();
    return big ? {26'd0, oa16} : {30'd0, oa4};
  endfunction
  function automatic logic cur_busy();
    return big ? busy16 : busy4;
  endfunction
  function automatic logic cur_done();
    return big ? done16 : done4;
  endfunction

  task automatic drive(input bit st, input bit v, input int d);
    st4 = 1'b0; v4 = 1'b0; d4 = '0;
    st16 = 1'b0; v16 = 1'b0; d16 = '0;
    if (big) begin
      st16 = st; v16 = v; d16 = 16'(d);
    end else begin
      st4 = st; v4 = v; d4 = 16'(d);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, cur_ov()}, {31'd0, e_valid});
    chk("out_data", cur_od(), e_data);
    chk("out_addr", cur_oa(), e_addr);
    chk("busy", {31'd0, cur_busy()}, {31'd0, e_busy});
    chk("done", {31'd0, cur_done()}, {31'd0, e_done});
    if (cur_ov() === 1'b1) n_out++;
  endtask

  // Frame-level model: collects accepted samples and pools each 2x2 block when its last sample lands.
  task automatic model_update(input bit st, input bit v, input int d);
    int r, c;
    e_valid = 1'b0;
    e_done  = 1'b0;
    case (phase)
      0: if (st) begin
        phase = 1; k = 0; samp.delete(); e_busy = 1'b1;
      end
      1: if (v) begin
        samp.push_back(relu(d));
        r = k / W;
        c = k % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          e_valid = 1'b1;
          e_data  = max2(max2(samp[k], samp[k-1]), max2(samp[k-W], samp[k-W-1]));
          e_addr  = (r / 2) * (W / 2) + c / 2;
        end
        k++;
        if (k == W * H) phase = 2;
      end
      default: begin
        phase = 0; e_busy = 1'b0; e_done = 1'b1;
      end
    endcase
  endtask

  task automatic step(input bit st, input bit v, input int d);
    @(negedge clk);
    check_outputs();
    drive(st, v, d);
    model_update(st, v, d);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);
    #2;
    chk("rst_out_valid", {31'd0, cur_ov()}, 0);
    chk("rst_out_data", cur_od(), 0);
    chk("rst_out_addr", cur_oa(), 0);
    chk("rst_busy", {31'd0, cur_busy()}, 0);
    chk("rst_done", {31'd0, cur_done()}, 0);
    phase = 0; k = 0; samp.delete();
    e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_data = 0; e_addr = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    vec_t tbl[32];
    int fb[16];
    int d;
    logic signed [15:0] t;
    int relu_on;

`ifdef POOL_RELU_EN
    relu_on = 1;
`else
    relu_on = 0;
`endif
    fb = '{-3, -8, 9, -2, -1, -6, -5, -4, -7, -7, -9, -10, -20, -11, -30, -12};
    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{i, 1'b0, 0, 0};
      tbl[16 + i] = '{fb[i], 1'b0, 0, 0};
    end
    tbl[5]  = '{5, 1'b1, 5, 0};
    tbl[7]  = '{7, 1'b1, 7, 1};
    tbl[13] = '{13, 1'b1, 13, 2};
    tbl[15] = '{15, 1'b1, 15, 3};
    tbl[21] = '{-6, 1'b1, relu_on ? 0 : -1, 0};
    tbl[23] = '{-4, 1'b1, 9, 1};
    tbl[29] = '{-11, 1'b1, relu_on ? 0 : -7, 2};
    tbl[31] = '{-12, 1'b1, relu_on ? 0 : -9, 3};

    rst = 1'b0;
    drive(0, 0, 0);
    n_out = 0;
    reset_dut();

    // in_valid while idle must be ignored
    for (int i = 0; i < 3; i++) step(0, 1, 99);

    // table frames: 0..15 and a negative-block frame
    for (int f = 0; f < 2; f++) begin
      n_out = 0;
      step(1, 0, 0);
      for (int i = 0; i < 16; i++) begin
        step(0, 1, tbl[16 * f + i].din);
        @(posedge clk);
        #1;
        chk("tbl_valid", {31'd0, cur_ov()}, {31'd0, tbl[16 * f + i].exp_v});
        if (tbl[16 * f + i].exp_v) begin
          chk("tbl_data", cur_od(), tbl[16 * f + i].exp_d);
          chk("tbl_addr", cur_oa(), tbl[16 * f + i].exp_a);
        end
      end
      idle(3);
      chk("tbl_frame_outs", n_out, 4);
    end

    // in_valid low every other cycle
    n_out = 0;
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, i);
      step(0, 0, 0);
    end
    idle(3);
    chk("gap_frame_outs", n_out, 4);

    // start mid-frame and in FINISH are ignored
    n_out = 0;
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(i == 6, 1, i);
    step(1, 0, 0);
    idle(3);
    chk("restart_frame_outs", n_out, 4);

    // reset after 6 samples abandons the frame
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 100 + i);
    reset_dut();
    n_out = 0;
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, i);
    idle(3);
    chk("post_reset_outs", n_out, 4);

    // random signed 4x4 frames with random gaps
    for (int f = 0; f < 4; f++) begin
      n_out = 0;
      step(1, 0, 0);
      for (int i = 0; i < 16; i++) begin
        while ($urandom_range(0, 2) == 0) step(0, 0, $urandom_range(0, 50));
        d = int'($urandom_range(0, 40)) - 20;
        step(0, 1, d);
      end
      idle(3);
      chk("rand4_frame_outs", n_out, 4);
    end

    // default 16x16 random frame
    big = 1'b1; W = 16; H = 16;
    reset_dut();
    n_out = 0;
    step(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, 0, 0);
      t = 16'($urandom);
      d = t;
      step(0, 1, d);
    end
    idle(3);
    chk("rand16_frame_outs", n_out, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
